// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: program sequencer and fetch stage. Drives the ROM address,
// registers the returned word and hands it downstream over valid/ready.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           level; starts/restarts a run from IDLE or DONE
//   rom_addr        ROM address (= pc[ADDR_W-1:0])
//   rom_data        combinational ROM word for rom_addr
//   instr           registered instruction to the splitter/ALU
//   instr_valid     instr holds an unconsumed word
//   instr_ready     downstream accepts instr this cycle
//   pc              words loaded since the last start (ADDR_W+1 bits)
//   busy / done     high in RUN / DONE
//
// Optional macro FETCH_HALT_DECODE_EN: an all-ones ROM word ends the
// program early; the word itself is never delivered.

module instr_fetch_seq #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 19,
  parameter int PROG_LEN = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W:0]   pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LEN = PROG_LEN[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  logic load_opp;
  logic more;
  logic halt;
  logic fetch;

  // The output register is free when empty or being drained this edge.
  assign load_opp = !valid_q || instr_ready;
  assign more     = pc_q < LEN;

`ifdef FETCH_HALT_DECODE_EN
  assign halt = (&rom_data) && load_opp;
`else
  assign halt = 1'b0;
`endif

  assign fetch = load_opp && more && !halt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (fetch) begin
          instr_d = rom_data;
          valid_d = 1'b1;
          pc_d    = pc_q + ONE;
        end else if (!more || halt) begin
          // End of program: drain the held word, then finish.
          if (!valid_q) begin
            state_d = DONE;
          end else if (instr_ready) begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign rom_addr    = pc_q[ADDR_W-1:0];
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed bench for instr_fetch_seq.
// Three instances: PROG_LEN=9 (main), PROG_LEN=0, PROG_LEN=64.

module tb_instr_fetch_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // main instance
  logic        start_a = 1'b0;
  logic        ready_a = 1'b0;
  logic [5:0]  rom_addr_a;
  logic [18:0] rom_data_a;
  logic [18:0] instr_a;
  logic        valid_a;
  logic [6:0]  pc_a;
  logic        busy_a;
  logic        done_a;
  logic [18:0] rom_a [64];

  assign rom_data_a = rom_a[rom_addr_a];

  instr_fetch_seq #(.ADDR_W(6), .DATA_W(19), .PROG_LEN(9)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .instr(instr_a), .instr_valid(valid_a), .instr_ready(ready_a),
    .pc(pc_a), .busy(busy_a), .done(done_a)
  );

  // PROG_LEN=0 instance
  logic        start_z = 1'b0;
  logic        ready_z = 1'b1;
  logic [5:0]  rom_addr_z;
  logic [18:0] rom_data_z;
  logic [18:0] instr_z;
  logic        valid_z;
  logic [6:0]  pc_z;
  logic        busy_z;
  logic        done_z;

  assign rom_data_z = 19'h12345;

  instr_fetch_seq #(.ADDR_W(6), .DATA_W(19), .PROG_LEN(0)) u_z (
    .clk(clk), .rst_n(rst_n), .start(start_z),
    .rom_addr(rom_addr_z), .rom_data(rom_data_z),
    .instr(instr_z), .instr_valid(valid_z), .instr_ready(ready_z),
    .pc(pc_z), .busy(busy_z), .done(done_z)
  );

  // PROG_LEN=64 instance; word encodes its own address
  logic        start_f = 1'b0;
  logic        ready_f = 1'b1;
  logic [5:0]  rom_addr_f;
  logic [18:0] rom_data_f;
  logic [18:0] instr_f;
  logic        valid_f;
  logic [6:0]  pc_f;
  logic        busy_f;
  logic        done_f;

  assign rom_data_f = {13'h0A5, rom_addr_f};

  instr_fetch_seq #(.ADDR_W(6), .DATA_W(19), .PROG_LEN(64)) u_f (
    .clk(clk), .rst_n(rst_n), .start(start_f),
    .rom_addr(rom_addr_f), .rom_data(rom_data_f),
    .instr(instr_f), .instr_valid(valid_f), .instr_ready(ready_f),
    .pc(pc_f), .busy(busy_f), .done(done_f)
  );

  logic [18:0] exp_w [9];
  int checks = 0;
  int passes = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if ({pc_a, instr_a, valid_a, busy_a, done_a, rom_addr_a} !== 36'h0)
      $display("FAIL reset_a: pc=%h instr=%h v=%b b=%b d=%b want all 0",
               pc_a, instr_a, valid_a, busy_a, done_a);
    else passes++;
    checks++;
    if ({pc_z, valid_z, busy_z, done_z} !== 10'h0)
      $display("FAIL reset_z: pc=%h v=%b b=%b d=%b want all 0",
               pc_z, valid_z, busy_z, done_z);
    else passes++;
    checks++;
    if ({pc_f, instr_f, valid_f, busy_f, done_f} !== 30'h0)
      $display("FAIL reset_f: pc=%h instr=%h v=%b b=%b d=%b want all 0",
               pc_f, instr_f, valid_f, busy_f, done_f);
    else passes++;
  endtask

  task automatic test_full_run();
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0 || pc_a !== 7'd0)
      $display("FAIL full_start: busy=%b valid=%b pc=%0d want 1 0 0",
               busy_a, valid_a, pc_a);
    else passes++;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (valid_a !== 1'b1 || instr_a !== exp_w[i] || pc_a !== 7'(i + 1))
        $display("FAIL full_word%0d: v=%b instr=%h pc=%0d want 1 %h %0d",
                 i, valid_a, instr_a, pc_a, exp_w[i], i + 1);
      else passes++;
    end
    tick();
    tick();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || pc_a !== 7'd9 ||
        valid_a !== 1'b0)
      $display("FAIL full_done: d=%b b=%b pc=%0d v=%b want 1 0 9 0",
               done_a, busy_a, pc_a, valid_a);
    else passes++;
  endtask

  task automatic test_restart();
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || pc_a !== 7'd0)
      $display("FAIL restart_entry: b=%b d=%b pc=%0d want 1 0 0",
               busy_a, done_a, pc_a);
    else passes++;
    for (int i = 0; i < 9; i++) begin
      start_a = (i == 3);
      tick();
      checks++;
      if (instr_a !== exp_w[i] || pc_a !== 7'(i + 1))
        $display("FAIL restart_word%0d: instr=%h pc=%0d want %h %0d",
                 i, instr_a, pc_a, exp_w[i], i + 1);
      else passes++;
    end
    start_a = 1'b0;
    tick();
    tick();
    checks++;
    if (done_a !== 1'b1 || pc_a !== 7'd9)
      $display("FAIL restart_done: d=%b pc=%0d want 1 9", done_a, pc_a);
    else passes++;
  endtask

  task automatic test_backpressure();
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_a !== 19'h1034C || valid_a !== 1'b1 || pc_a !== 7'd2 ||
          rom_addr_a !== 6'd2)
        $display("FAIL bp_hold%0d: instr=%h v=%b pc=%0d addr=%0d want 1034c 1 2 2",
                 i, instr_a, valid_a, pc_a, rom_addr_a);
      else passes++;
    end
    ready_a = 1'b1;
    for (int i = 2; i < 9; i++) begin
      tick();
      checks++;
      if (instr_a !== exp_w[i] || pc_a !== 7'(i + 1))
        $display("FAIL bp_word%0d: instr=%h pc=%0d want %h %0d",
                 i, instr_a, pc_a, exp_w[i], i + 1);
      else passes++;
    end
    tick();
    tick();
    checks++;
    if (done_a !== 1'b1 || pc_a !== 7'd9)
      $display("FAIL bp_done: d=%b pc=%0d want 1 9", done_a, pc_a);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc_a !== 7'd4)
      $display("FAIL midrst_pc: pc=%0d want 4", pc_a);
    else passes++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({pc_a, instr_a, valid_a, busy_a, done_a} !== 30'h0)
      $display("FAIL midrst_state: pc=%h instr=%h v=%b b=%b d=%b want all 0",
               pc_a, instr_a, valid_a, busy_a, done_a);
    else passes++;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    checks++;
    if (instr_a !== 19'h01713 || valid_a !== 1'b1 || pc_a !== 7'd1)
      $display("FAIL midrst_first: instr=%h v=%b pc=%0d want 01713 1 1",
               instr_a, valid_a, pc_a);
    else passes++;
    cyc = 0;
    while (!done_a && cyc < 30) begin
      tick();
      cyc++;
    end
    checks++;
    if (done_a !== 1'b1 || pc_a !== 7'd9)
      $display("FAIL midrst_finish: d=%b pc=%0d after %0d cycles want 1 9",
               done_a, pc_a, cyc);
    else passes++;
  endtask

  task automatic test_prog_len_zero();
    int seen;
    seen = 0;
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    checks++;
    if (busy_z !== 1'b1)
      $display("FAIL zero_busy: busy=%b want 1", busy_z);
    else passes++;
    if (valid_z) seen++;
    tick();
    checks++;
    if (done_z !== 1'b1 || busy_z !== 1'b0 || pc_z !== 7'd0)
      $display("FAIL zero_done: d=%b b=%b pc=%0d want 1 0 0",
               done_z, busy_z, pc_z);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      if (valid_z) seen++;
      tick();
    end
    checks++;
    if (seen != 0)
      $display("FAIL zero_valid: valid seen %0d cycles want 0", seen);
    else passes++;
  endtask

  task automatic test_prog_len_max();
    logic [5:0]  a6;
    logic [18:0] w;
    int bad;
    bad = 0;
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      a6 = i[5:0];
      w = {13'h0A5, a6};
      checks++;
      if (instr_f !== w || valid_f !== 1'b1 || pc_f !== 7'(i + 1)) begin
        if (bad < 4)
          $display("FAIL max_word%0d: instr=%h v=%b pc=%0d want %h 1 %0d",
                   i, instr_f, valid_f, pc_f, w, i + 1);
        bad++;
      end else passes++;
    end
    tick();
    tick();
    checks++;
    if (done_f !== 1'b1 || pc_f !== 7'd64 || valid_f !== 1'b0)
      $display("FAIL max_done: d=%b pc=%0d v=%b want 1 64 0",
               done_f, pc_f, valid_f);
    else passes++;
  endtask

  task automatic test_all_ones_word();
    logic [18:0] got [64];
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    rom_a[3] = 19'h7FFFF;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (!done_a && cyc < 40) begin
      if (valid_a && ready_a && n < 64) begin
        got[n] = instr_a;
        n++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (done_a !== 1'b1)
      $display("FAIL ones_timeout: done=%b after %0d cycles want 1",
               done_a, cyc);
    else passes++;
`ifdef FETCH_HALT_DECODE_EN
    checks++;
    if (n != 3 || pc_a !== 7'd3)
      $display("FAIL halt_count: transfers=%0d pc=%0d want 3 3", n, pc_a);
    else passes++;
    checks++;
    if (n < 3 || got[0] !== exp_w[0] || got[1] !== exp_w[1] ||
        got[2] !== exp_w[2])
      $display("FAIL halt_words: n=%0d w2=%h want 3 %h",
               n, got[2], exp_w[2]);
    else passes++;
`else
    checks++;
    if (n != 9 || pc_a !== 7'd9)
      $display("FAIL ones_count: transfers=%0d pc=%0d want 9 9", n, pc_a);
    else passes++;
    checks++;
    if (n < 5 || got[3] !== 19'h7FFFF || got[4] !== exp_w[4])
      $display("FAIL ones_word3: n=%0d w3=%h w4=%h want 7ffff %h",
               n, got[3], got[4], exp_w[4]);
    else passes++;
`endif
    rom_a[3] = exp_w[3];
  endtask

  initial begin
    exp_w[0] = 19'h01713;
    exp_w[1] = 19'h1034C;
    exp_w[2] = 19'h1074C;
    exp_w[3] = 19'h21F05;
    exp_w[4] = 19'h31F02;
    exp_w[5] = 19'h45D52;
    exp_w[6] = 19'h55D52;
    exp_w[7] = 19'h65D52;
    exp_w[8] = 19'h75D52;
    for (int i = 0; i < 64; i++) rom_a[i] = 19'(i + 19'h40000);
    for (int i = 0; i < 9; i++) rom_a[i] = exp_w[i];

    test_reset();
    test_full_run();
    test_restart();
    test_backpressure();
    test_reset_mid_run();
    test_prog_len_zero();
    test_prog_len_max();
    test_all_ones_word();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
